dut_run_ctrl: RTL



---
 rtl/dut_run_ctrl.sv | 103 ++++++++++
 1 files changed

// File: rtl/dut_run_ctrl.sv
// dut_run_ctrl: run sequencer and sticky pass-vector monitor for the BRAM test DUT; optional soak loop under DUT_RUN_LOOP_EN
module dut_run_ctrl #(
  parameter int NUM = 10,
  parameter int SETTLE_CYCLES = 64,
  parameter int RUN_CYCLES = 1024,
  parameter int GUARD_CYCLES = 8,
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W = 16
) (
  input  logic             ref_clk_in,
  input  logic             reset,
  input  logic             go,
  input  logic             abort,
  input  logic [NUM-1:0]   pass_in,
  output logic             clock_en_out,
  output logic             start_out,
  output logic             stop_out,
  output logic             busy,
  output logic             done,
  output logic             result_pass,
  output logic             aborted,
  output logic [NUM-1:0]   fail_mask,
  output logic [CNT_W-1:0] run_count,
  output logic [CNT_W-1:0] fail_count
);
  localparam int CW = $clog2(SETTLE_CYCLES + RUN_CYCLES + DRAIN_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, SETTLE, RUN, STOP, DRAIN, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [NUM-1:0] pass_d;
  logic pass_ok;
  assign pass_ok = ~|fail_mask & ~aborted;
  // sequencer: control outputs are decoded from the current state one edge later, mask and stats update in place
  always_ff @(posedge ref_clk_in) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      pass_d <= '0;
      clock_en_out <= 1'b0;
      start_out <= 1'b0;
      stop_out <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      result_pass <= 1'b0;
      aborted <= 1'b0;
      fail_mask <= '0;
      run_count <= '0;
      fail_count <= '0;
    end else begin
      pass_d <= pass_in;
      clock_en_out <= state inside {SETTLE, RUN, STOP, DRAIN};
      start_out <= state == RUN;
      stop_out <= state == STOP;
      busy <= state != IDLE;
      done <= state == DONE;
      cnt <= cnt + CW'(1);
      case (state)
        IDLE: if (go && !abort) begin
          state <= SETTLE;
          cnt <= '0;
          fail_mask <= '0;
          aborted <= 1'b0;
        end
        SETTLE: if (abort) begin
          state <= STOP;
          aborted <= 1'b1;
        end else if (cnt == CW'(SETTLE_CYCLES - 1)) begin
          state <= RUN;
          cnt <= '0;
        end
        RUN: begin
          if (cnt >= CW'(GUARD_CYCLES)) fail_mask <= fail_mask | ~pass_d;
          if (abort) begin
            state <= STOP;
            aborted <= 1'b1;
          end else if (cnt == CW'(RUN_CYCLES - 1)) state <= STOP;
        end
        STOP: begin
          state <= DRAIN;
          cnt <= '0;
        end
        DRAIN: if (cnt == CW'(DRAIN_CYCLES - 1)) state <= DONE;
        DONE: begin
          result_pass <= pass_ok;
          if (!aborted) begin
            if (~&run_count) run_count <= run_count + CNT_W'(1);
            if (|fail_mask && ~&fail_count) fail_count <= fail_count + CNT_W'(1);
          end
`ifdef DUT_RUN_LOOP_EN
          if (pass_ok && !abort) begin
            state <= SETTLE;
            cnt <= '0;
            fail_mask <= '0;
          end else state <= IDLE;
`else
          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
